accel_axil_reg_slave: RTL and testbench
=======================================

// Module: accel_axil_reg_slave
// PURPOSE
//  AXI4-Lite responder holding the ACCEL control/data register bank; answers the AXI4-Lite master BFM/PS.
//  NUM_REGS x 32-bit read/write registers at byte offsets 0x0,0x4,0x8,... are exposed flat to the datapath.
//  A one-cycle write strobe per register tells the accelerator core that software updated it.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  6   byte address width; bits [1:0] are ignored
//  NUM_REGS            4   number of implemented registers (NUM_REGS*4 <= 2**C_S_AXI_ADDR_WIDTH)
// PORTS
//  ACLK           in   1          sole clock, rising edge
//  ARESET         in   1          asynchronous reset, active-high
//  S_AXI_AWADDR   in   ADDR_W     write address
//  S_AXI_AWPROT   in   3          ignored
//  S_AXI_AWVALID  in   1          write address valid
//  S_AXI_AWREADY  out  1          write address ready
//  S_AXI_WDATA    in   32         write data
//  S_AXI_WSTRB    in   4          byte enables
//  S_AXI_WVALID   in   1          write data valid
//  S_AXI_WREADY   out  1          write data ready
//  S_AXI_BRESP    out  2          00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1          write response valid
//  S_AXI_BREADY   in   1          write response ready
//  S_AXI_ARADDR   in   ADDR_W     read address
//  S_AXI_ARPROT   in   3          ignored
//  S_AXI_ARVALID  in   1          read address valid
//  S_AXI_ARREADY  out  1          read address ready
//  S_AXI_RDATA    out  32         read data
//  S_AXI_RRESP    out  2          00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1          read data valid
//  S_AXI_RREADY   in   1          read data ready
//  reg_q          out  NUM_REGS*32  register contents; reg i = reg_q[32*i+:32]
//  reg_wr_pulse   out  NUM_REGS   1-cycle pulse when reg i is written (any strobe)
// BEHAVIOUR
//  Reset (ARESET=1, async): all registers 0, BVALID/RVALID 0, RDATA 0, BRESP/RRESP 00, reg_wr_pulse 0,
//   AW/W hold flags cleared. An in-flight transaction is dropped; READY outputs follow the rules below after release.
//  Write path: AW and W are accepted independently and in either order.
//   AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID. A handshake latches address/data+strobe and sets the hold flag.
//   Commit happens on the first edge where both flags are set (latency 1 cycle after the later handshake):
//   update the selected register byte-wise per WSTRB, pulse reg_wr_pulse[i], set BVALID, clear both flags.
//  Address index = addr[ADDR_W-1:2]; index >= NUM_REGS -> no register change, no pulse, BRESP=SLVERR.
//  BVALID is held until BREADY; no new AW/W is accepted while BVALID=1. Only one write is outstanding.
//  Read path: ARREADY = !RVALID. On AR handshake, on the same edge: RDATA <= reg[idx] (0 if out of range),
//   RRESP <= OKAY/SLVERR, RVALID <= 1. RDATA/RRESP are held stable until RVALID&RREADY, then RVALID <= 0.
//  Read and write paths are independent; a read of reg i on the commit edge of a write to reg i returns the OLD value.
//  WSTRB=0000 to a valid address: OKAY response and pulse, data unchanged.
// TESTING
//  1 Write 0x0101FFFF,0xABCD0001,0xDEAD0011,0xBEEF0011 to 0x0..0xC, read each back -> same data, RESP=00.
//  2 W presented 3 cycles before AW (addr 0x4, data 0x12345678) -> BVALID 1 cycle after AW handshake, reg1=0x12345678.
//  3 reg2=0xDEAD0011, then write 0x0000AA00 WSTRB=0010 to 0x8 -> readback 0xDEADAA11, reg_wr_pulse[2] high exactly 1 cycle.
//  4 Write to 0x10 and read from 0x3C -> BRESP=10, RRESP=10, RDATA=0, no reg_q change, no pulse.
//  5 Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RDATA stable; AWREADY/WREADY/ARREADY stay 0.
//  6 Assert ARESET while BVALID=1 and RVALID=1 -> both drop immediately, reg_q=0; a fresh write/read after release completes OKAY.

Source files
------------

// File: rtl/accel_axil_reg_slave.sv
// AXI4-Lite responder for the ACCEL control/data register bank.
// Registers are exposed flat on reg_q. reg_wr_pulse marks each register that software updated.
module accel_axil_reg_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic             aw_held;
  logic             w_held;
  logic [IDX_W-1:0] aw_idx;
  logic [DW-1:0]    w_data;
  logic [SW-1:0]    w_strb;

  logic                commit_c;
  logic [NUM_REGS-1:0] wr_sel_c;
  logic                wr_hit_c;
  logic [IDX_W-1:0]    ar_idx_c;
  logic [DW-1:0]       rd_data_c;
  logic                rd_hit_c;
  logic                unused_c;

  // Protection bits and the byte-lane address bits carry no meaning here
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Channels stall while a slot is occupied or a response is pending
  assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;

  assign ar_idx_c = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Write commit decode: both halves held selects the addressed register
  always_comb begin
    commit_c = aw_held && w_held;
    wr_sel_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (commit_c && (aw_idx == IDX_W'(i))) wr_sel_c[i] = 1'b1;
    end
    wr_hit_c = |wr_sel_c;
  end

  // Read mux; out-of-range indices return zero
  always_comb begin
    rd_data_c = '0;
    rd_hit_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_c == IDX_W'(i)) begin
        rd_data_c = reg_q[DW*i +: DW];
        rd_hit_c  = 1'b1;
      end
    end
  end

  // Write address/data hold slots and the write response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (commit_c) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_hit_c ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Register bank: byte-lane update and one-cycle update pulse on commit
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      reg_q        <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= wr_sel_c;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        for (int unsigned b = 0; b < SW; b++) begin
          if (wr_sel_c[i] && w_strb[b]) reg_q[DW*i + 8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel: capture on address handshake, hold until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data_c;
        S_AXI_RRESP  <= rd_hit_c ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_axil_reg_slave.sv
// Self-checking bench for accel_axil_reg_slave against a register-array reference model.
module tb_accel_axil_reg_slave;

  logic         tb_ACLK;
  logic         tb_ARESET;
  logic [5:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [5:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [4];

  accel_axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS(4)
  ) dut (
    .ACLK(tb_ACLK),
    .ARESET(tb_ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA),
    .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_q();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] addr);
    int idx = int'(addr[5:2]);
    return (idx < 4) ? m[idx] : 32'h0;
  endfunction

  // Reference write: byte lanes of the addressed register, nothing outside the bank
  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [3:0] pulse, output logic [1:0] resp);
    int idx = int'(addr[5:2]);
    pulse = 4'h0;
    resp  = 2'b10;
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) if (strb[b]) m[idx][8*b +: 8] = data[8*b +: 8];
      pulse = 4'(1) << idx;
      resp  = 2'b00;
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0, lat = 0;
    logic [3:0] exp_pulse;
    logic [1:0] exp_resp;
    while (!(aw_done && w_done) && c < 50) begin
      @(negedge tb_ACLK);
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = !aw_done && (c >= aw_dly);
      S_AXI_WVALID  = !w_done && (c >= w_dly);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge tb_ACLK);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      c++;
    end
    @(negedge tb_ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    chk("wr_handshakes", 128'({aw_done, w_done}), 128'(2'b11));
    while (!S_AXI_BVALID && lat < 10) begin
      @(posedge tb_ACLK);
      lat++;
      @(negedge tb_ACLK);
    end
    model_write(addr, data, strb, exp_pulse, exp_resp);
    chk("b_latency", 128'(lat), 128'(1));
    chk("bvalid", 128'(S_AXI_BVALID), 128'(1'b1));
    chk("bresp", 128'(S_AXI_BRESP), 128'(exp_resp));
    chk("wr_pulse", 128'(reg_wr_pulse), 128'(exp_pulse));
    chk("reg_q_after_wr", reg_q, model_q());
    S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clear", 128'(S_AXI_BVALID), 128'(1'b0));
    chk("wr_pulse_clear", 128'(reg_wr_pulse), 128'(0));
  endtask

  task automatic axi_read(input logic [5:0] addr);
    int c = 0;
    logic [31:0] exp_data = model_read(addr);
    logic [1:0]  exp_resp = (addr[5:2] < 4'd4) ? 2'b00 : 2'b10;
    @(negedge tb_ACLK);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && c < 10) begin
      @(negedge tb_ACLK);
      c++;
    end
    chk("arready", 128'(S_AXI_ARREADY), 128'(1'b1));
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_ARVALID = 1'b0;
    chk("rvalid", 128'(S_AXI_RVALID), 128'(1'b1));
    chk("rdata", 128'(S_AXI_RDATA), 128'(exp_data));
    chk("rresp", 128'(S_AXI_RRESP), 128'(exp_resp));
    S_AXI_RREADY = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_RREADY = 1'b0;
    chk("rvalid_clear", 128'(S_AXI_RVALID), 128'(1'b0));
  endtask

  initial begin
    logic [31:0] old_val;
    logic [3:0]  tmp_pulse;
    logic [1:0]  tmp_resp;
    logic [5:0]  addr;

    tb_ARESET     = 1'b1;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge tb_ACLK);
    chk("rst_reg_q", reg_q, 128'h0);
    chk("rst_bvalid", 128'(S_AXI_BVALID), 128'(1'b0));
    chk("rst_rvalid", 128'(S_AXI_RVALID), 128'(1'b0));
    chk("rst_rdata", 128'(S_AXI_RDATA), 128'(0));
    chk("rst_pulse", 128'(reg_wr_pulse), 128'(0));
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    chk("idle_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));

    // Basic write then readback of every register
    axi_write(6'h00, 32'h0101FFFF, 4'hF, 0, 0);
    axi_write(6'h04, 32'hABCD0001, 4'hF, 0, 0);
    axi_write(6'h08, 32'hDEAD0011, 4'hF, 0, 0);
    axi_write(6'h0C, 32'hBEEF0011, 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(6'(4 * i));

    // Data ahead of address by three cycles
    axi_write(6'h04, 32'h12345678, 4'hF, 3, 0);
    chk("reg1_w_first", 128'(reg_q[63:32]), 128'(32'h12345678));
    // Address ahead of data
    axi_write(6'h0C, 32'h0BADF00D, 4'hF, 0, 2);

    // Single-lane strobe merge
    axi_write(6'h08, 32'h0000AA00, 4'b0010, 0, 0);
    axi_read(6'h08);
    chk("reg2_merge", 128'(reg_q[95:64]), 128'(32'hDEADAA11));

    // Empty strobe: OKAY, pulse, no change
    axi_write(6'h00, 32'hFFFFFFFF, 4'b0000, 1, 1);

    // Out-of-range accesses
    axi_write(6'h10, 32'h55555555, 4'hF, 0, 0);
    axi_read(6'h3C);
    axi_read(6'h13);

    // Read on the commit edge sees the old value; then both responses stall
    old_val = m[1];
    @(negedge tb_ACLK);
    S_AXI_AWADDR  = 6'h04;
    S_AXI_WDATA   = 32'hCAFEF00D;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARADDR  = 6'h04;
    S_AXI_ARVALID = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_ARVALID = 1'b0;
    model_write(6'h04, 32'hCAFEF00D, 4'hF, tmp_pulse, tmp_resp);
    chk("rd_old_on_commit", 128'(S_AXI_RDATA), 128'(old_val));
    chk("reg_q_commit", reg_q, model_q());
    for (int k = 0; k < 5; k++) begin
      chk("stall_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b11));
      chk("stall_bresp", 128'(S_AXI_BRESP), 128'(2'b00));
      chk("stall_rdata", 128'(S_AXI_RDATA), 128'(old_val));
      chk("stall_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
      @(negedge tb_ACLK);
    end
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    chk("stall_release", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));

    // Randomised traffic against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) addr = {2'b00, 2'($urandom_range(0, 3)), 2'($urandom)};
      else addr = 6'($urandom_range(16, 63));
      if ($urandom_range(0, 1) == 0)
        axi_write(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(addr);
    end

    // Asynchronous reset with both responses pending
    @(negedge tb_ACLK);
    S_AXI_AWADDR  = 6'h08;
    S_AXI_WDATA   = 32'h77778888;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 6'h00;
    S_AXI_ARVALID = 1'b1;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("pre_rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b11));
    #1 tb_ARESET = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) m[i] = 32'h0;
    chk("arst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
    chk("arst_reg_q", reg_q, 128'h0);
    chk("arst_rdata", 128'(S_AXI_RDATA), 128'(0));
    @(negedge tb_ACLK);
    tb_ARESET = 1'b0;
    axi_write(6'h0C, 32'h600DCAFE, 4'hF, 0, 0);
    axi_read(6'h0C);
    axi_read(6'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
